// File: rtl/viterbi_pkg.sv
// Shared types and sizing helpers for the Viterbi add-compare-select datapath.
package viterbi_pkg;
   typedef enum logic [1:0] {IDLE, ACS, COMMIT} fsm_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

   function automatic int S_OF(input int m);
      return 1 << (m - 1);
   endfunction

   function automatic int BM_W_OF(input int n);
      return clog2(n + 1);
   endfunction
endpackage

// File: rtl/viterbi_branch_metric.sv
// Hamming distance between the received symbol and the code word the encoder
// would emit for input u from state p.
module viterbi_branch_metric
   import viterbi_pkg::*;
#(
   parameter int N    = 2,
   parameter int M    = 4,
   parameter int BM_W = BM_W_OF(N)
) (
   input  logic [N-1:0][0:M-1] g,
   input  logic [0:M-2]        p,
   input  logic                u,
   input  logic [0:N-1]        sym,
   output logic [BM_W-1:0]     bm
);
   always_comb begin
      bm = '0;
      for (int x = 0; x < N; x++) begin
         bm = bm + BM_W'((^(g[x] & {u, p})) ^ sym[x]);
      end
   end
endmodule

// File: rtl/viterbi_acs_unit.sv
// Serial add-compare-select engine: one next state per cycle, normalised commit,
// one survivor-decision word per received symbol.
module viterbi_acs_unit
   import viterbi_pkg::*;
#(
   parameter  int N      = 2,
   parameter  int M      = 4,
   parameter  int PM_W   = 8,
   localparam int S      = S_OF(M),
   localparam int ADDR_W = (clog2(N) < 1) ? 1 : clog2(N)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] address,
   input  logic [0:M-1]      data,
   input  logic              frame_start,
   input  logic              sym_valid,
   output logic              sym_ready,
   input  logic [0:N-1]      sym,
   output logic              dec_valid,
   output logic [S-1:0]      dec_bits,
   output logic [M-2:0]      best_state
);
   localparam int              BM_W    = BM_W_OF(N);
   localparam logic [PM_W-1:0] PM_MAX  = '1;
   localparam logic [M-2:0]    NS_LAST = '1;

   fsm_t                fsm;
   logic [N-1:0][0:M-1] g_r;
   logic [PM_W-1:0]     pm  [S];
   logic [PM_W-1:0]     npm [S];
   logic [0:N-1]        sym_r;
   logic [M-2:0]        ns;
   logic [S-1:0]        dec_work;
   logic [PM_W-1:0]     min_pm;
   logic [M-2:0]        min_idx;
   logic                u;
   logic [0:M-2]        p0, p1;
   logic [BM_W-1:0]     bm0, bm1;
   logic [PM_W-1:0]     c0, c1, win;
   logic                choose1;

   function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a,
                                               input logic [BM_W-1:0] b);
      logic [PM_W:0] s;
      s = {1'b0, a} + (PM_W + 1)'(b);
      return s[PM_W] ? PM_MAX : s[PM_W-1:0];
   endfunction

   assign sym_ready = (fsm == IDLE) & ~frame_start;

   // next state ns = {u, q}; its two predecessors differ only in the oldest bit
   assign u  = ns[M-2];
   assign p0 = {ns[M-3:0], 1'b0};
   assign p1 = {ns[M-3:0], 1'b1};

   viterbi_branch_metric #(.N(N), .M(M), .BM_W(BM_W)) u_bm0 (
      .g(g_r), .p(p0), .u(u), .sym(sym_r), .bm(bm0)
   );
   viterbi_branch_metric #(.N(N), .M(M), .BM_W(BM_W)) u_bm1 (
      .g(g_r), .p(p1), .u(u), .sym(sym_r), .bm(bm1)
   );

   always_comb begin
      c0      = sat_add(pm[p0], bm0);
      c1      = sat_add(pm[p1], bm1);
      choose1 = (c1 < c0);
      win     = choose1 ? c1 : c0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm        <= IDLE;
         ns         <= '0;
         g_r        <= '0;
         dec_valid  <= 1'b0;
         dec_bits   <= '0;
         best_state <= '0;
         for (int k = 0; k < S; k++) pm[k] <= (k == 0) ? '0 : PM_MAX;
      end else begin
         dec_valid <= 1'b0;
         unique case (fsm)
            IDLE: begin
               if (load && (32'(address) < N)) g_r[address] <= data;
               if (frame_start) begin
                  for (int k = 0; k < S; k++) pm[k] <= (k == 0) ? '0 : PM_MAX;
               end else if (sym_valid) begin
                  ns  <= '0;
                  fsm <= ACS;
               end
            end
            ACS: begin
               if (frame_start) begin
                  for (int k = 0; k < S; k++) pm[k] <= (k == 0) ? '0 : PM_MAX;
                  fsm <= IDLE;
               end else begin
                  ns <= ns + 1'b1;
                  if (ns == NS_LAST) fsm <= COMMIT;
               end
            end
            COMMIT: begin
               if (frame_start) begin
                  for (int k = 0; k < S; k++) pm[k] <= (k == 0) ? '0 : PM_MAX;
               end else begin
                  for (int k = 0; k < S; k++) pm[k] <= npm[k] - min_pm;
                  dec_bits   <= dec_work;
                  best_state <= min_idx;
                  dec_valid  <= 1'b1;
               end
               fsm <= IDLE;
            end
            default: fsm <= IDLE;
         endcase
      end
   end

   // candidate buffer and running minimum; fully rewritten every step
   always_ff @(posedge clk) begin
      if (fsm == IDLE && sym_valid && sym_ready) sym_r <= sym;
      if (fsm == ACS) begin
         npm[ns]      <= win;
         dec_work[ns] <= choose1;
         if (ns == '0 || win < min_pm) begin
            min_pm  <= win;
            min_idx <= ns;
         end
      end
   end
endmodule
